// File: rtl/blit_ctrl_if.sv
// Framebuffer port B bus: one access outstanding, strobe for one cycle, hold until rdy_b.
interface blit_ctrl_if;
  logic [8:0] x_b;
  logic [7:0] y_b;
  logic       read_b;
  logic       write_b;
  logic       in_b;
  logic       out_b;
  logic       rdy_b;

  modport master (output x_b, y_b, read_b, write_b, in_b, input out_b, rdy_b);
  modport slave  (input x_b, y_b, read_b, write_b, in_b, output out_b, rdy_b);
endinterface

// File: rtl/blit_ctrl.sv
// Rectangle FILL/COPY sequencer for framebuffer port B, with single-pixel host
// accesses interleaved between pixel operations.
module blit_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_start,
  input  logic       cmd_op,
  input  logic [8:0] cmd_x0,
  input  logic [8:0] cmd_x1,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_y1,
  input  logic [8:0] cmd_sx,
  input  logic [7:0] cmd_sy,
  input  logic       cmd_color,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [8:0] host_x,
  input  logic [7:0] host_y,
  input  logic       host_rd,
  input  logic       host_wr,
  input  logic       host_din,
  output logic       host_dout,
  output logic       host_rdy,
  blit_ctrl_if.master bus
);
  localparam logic [3:0] IDLE    = 4'd0,  CHECK   = 4'd1,  NEXT   = 4'd2,
                         H_ACC   = 4'd3,  H_WAIT  = 4'd4,  F_WR   = 4'd5,
                         F_WAIT  = 4'd6,  C_RD    = 4'd7,  C_RWAIT = 4'd8,
                         C_WR    = 4'd9,  C_WWAIT = 4'd10, ADV    = 4'd11;
  localparam logic [9:0] W_LIM = 10'(WIDTH);
  localparam logic [8:0] H_LIM = 9'(HEIGHT);

  logic [3:0] r_state, w_ns;
  logic       r_cmd_pend, r_op, r_color, r_rev, r_busy;
  logic [8:0] r_x0, r_x1, r_sx, r_sxe, r_cx, r_scx;
  logic [7:0] r_y0, r_y1, r_sy, r_sye, r_cy, r_scy;
  logic       r_hpend, r_hwr, r_hdin;
  logic [8:0] r_hx;
  logic [7:0] r_hy;
  logic       r_done, r_err, r_hrdy, r_hdout;
  logic [8:0] r_x_b;
  logic [7:0] r_y_b;
  logic       r_read_b, r_write_b, r_in_b;

  logic [9:0] w_sxe;
  logic [8:0] w_sye;
  logic       w_reject, w_rev, w_row_end, w_last, w_cmd_acc;
  logic [8:0] w_ncx, w_nscx;
  logic [7:0] w_ncy, w_nscy;

  // Source extents are computed one bit wider so an out-of-range copy cannot wrap into range.
  assign w_sxe = {1'b0, r_sx} + ({1'b0, r_x1} - {1'b0, r_x0});
  assign w_sye = {1'b0, r_sy} + ({1'b0, r_y1} - {1'b0, r_y0});
  assign w_reject = (r_x0 > r_x1) || (r_y0 > r_y1) ||
                    ({1'b0, r_x1} >= W_LIM) || ({1'b0, r_y1} >= H_LIM) ||
                    (r_op && ((w_sxe >= W_LIM) || (w_sye >= H_LIM)));
  // Destination below/right of source: scan backwards so overlapping copies read before overwrite.
  assign w_rev = r_op && ((r_y0 > r_sy) || ((r_y0 == r_sy) && (r_x0 > r_sx)));
  assign w_cmd_acc = cmd_start && !r_busy && (r_state != CHECK) && !r_cmd_pend;

  always_comb begin
    w_row_end = r_rev ? (r_cx == r_x0) : (r_cx == r_x1);
    w_last    = w_row_end && (r_rev ? (r_cy == r_y0) : (r_cy == r_y1));
    w_ncx     = r_rev ? r_cx - 9'd1 : r_cx + 9'd1;
    w_nscx    = r_rev ? r_scx - 9'd1 : r_scx + 9'd1;
    w_ncy     = r_cy;
    w_nscy    = r_scy;
    if (w_row_end) begin
      w_ncx  = r_rev ? r_x1 : r_x0;
      w_nscx = r_rev ? r_sxe : r_sx;
      w_ncy  = r_rev ? r_cy - 8'd1 : r_cy + 8'd1;
      w_nscy = r_rev ? r_scy - 8'd1 : r_scy + 8'd1;
    end
  end

  always_comb begin
    w_ns = r_state;
    case (r_state)
      IDLE:    if (r_hpend) w_ns = H_ACC; else if (r_cmd_pend) w_ns = CHECK;
      CHECK:   w_ns = w_reject ? IDLE : NEXT;
      NEXT:    w_ns = r_hpend ? H_ACC : (r_op ? C_RD : F_WR);
      H_ACC:   w_ns = H_WAIT;
      H_WAIT:  if (bus.rdy_b) w_ns = r_busy ? NEXT : IDLE;
      F_WR:    w_ns = F_WAIT;
      F_WAIT:  if (bus.rdy_b) w_ns = ADV;
      C_RD:    w_ns = C_RWAIT;
      C_RWAIT: if (bus.rdy_b) w_ns = C_WR;
      C_WR:    w_ns = C_WWAIT;
      C_WWAIT: if (bus.rdy_b) w_ns = ADV;
      // FILL skips NEXT when no host request is waiting, keeping it at three cycles per pixel.
      ADV:     if (w_last) w_ns = IDLE;
               else if (r_hpend) w_ns = H_ACC;
               else w_ns = r_op ? NEXT : F_WR;
      default: w_ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;  r_cmd_pend <= 1'b0; r_op <= 1'b0; r_color <= 1'b0;
      r_rev <= 1'b0;    r_busy <= 1'b0;
      r_x0 <= '0; r_x1 <= '0; r_sx <= '0; r_sxe <= '0; r_cx <= '0; r_scx <= '0;
      r_y0 <= '0; r_y1 <= '0; r_sy <= '0; r_sye <= '0; r_cy <= '0; r_scy <= '0;
      r_hpend <= 1'b0; r_hwr <= 1'b0; r_hdin <= 1'b0; r_hx <= '0; r_hy <= '0;
      r_done <= 1'b0; r_err <= 1'b0; r_hrdy <= 1'b0; r_hdout <= 1'b0;
      r_x_b <= '0; r_y_b <= '0; r_read_b <= 1'b0; r_write_b <= 1'b0; r_in_b <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_done  <= (r_state == ADV) && w_last;
      r_err   <= (r_state == CHECK) && w_reject;
      r_hrdy  <= (r_state == H_WAIT) && bus.rdy_b;

      if (w_cmd_acc) begin
        r_cmd_pend <= 1'b1;
        r_op <= cmd_op; r_color <= cmd_color;
        r_x0 <= cmd_x0; r_x1 <= cmd_x1; r_y0 <= cmd_y0; r_y1 <= cmd_y1;
        r_sx <= cmd_sx; r_sy <= cmd_sy;
      end else if (r_state == CHECK) begin
        r_cmd_pend <= 1'b0;
      end

      if (r_state == CHECK && !w_reject) begin
        r_busy <= 1'b1;
        r_rev  <= w_rev;
        r_sxe  <= w_sxe[8:0];
        r_sye  <= w_sye[7:0];
        r_cx   <= w_rev ? r_x1 : r_x0;
        r_cy   <= w_rev ? r_y1 : r_y0;
        r_scx  <= w_rev ? w_sxe[8:0] : r_sx;
        r_scy  <= w_rev ? w_sye[7:0] : r_sy;
      end else if (r_state == ADV) begin
        if (w_last) r_busy <= 1'b0;
        else begin
          r_cx <= w_ncx; r_cy <= w_ncy; r_scx <= w_nscx; r_scy <= w_nscy;
        end
      end

      // A strobe landing while a request is pending is dropped; write wins over read.
      if (r_state == H_WAIT && bus.rdy_b) begin
        r_hpend <= 1'b0;
        if (!r_hwr) r_hdout <= bus.out_b;
      end else if (!r_hpend && (host_rd || host_wr)) begin
        r_hpend <= 1'b1;
        r_hwr   <= host_wr;
        r_hdin  <= host_din;
        r_hx    <= host_x;
        r_hy    <= host_y;
      end

      r_read_b  <= (w_ns == C_RD) || (w_ns == H_ACC && !r_hwr);
      r_write_b <= (w_ns == F_WR) || (w_ns == C_WR) || (w_ns == H_ACC && r_hwr);
      case (w_ns)
        H_ACC: begin r_x_b <= r_hx; r_y_b <= r_hy; r_in_b <= r_hwr & r_hdin; end
        F_WR: begin
          r_x_b  <= (r_state == ADV) ? w_ncx : r_cx;
          r_y_b  <= (r_state == ADV) ? w_ncy : r_cy;
          r_in_b <= r_color;
        end
        C_RD:  begin r_x_b <= r_scx; r_y_b <= r_scy; r_in_b <= 1'b0; end
        // The read data goes straight into the held write data register.
        C_WR:  begin r_x_b <= r_cx; r_y_b <= r_cy; r_in_b <= bus.out_b; end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign host_rdy    = r_hrdy;
  assign host_dout   = r_hdout;
  assign bus.x_b     = r_x_b;
  assign bus.y_b     = r_y_b;
  assign bus.read_b  = r_read_b;
  assign bus.write_b = r_write_b;
  assign bus.in_b    = r_in_b;
endmodule
